// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared state encoding and helpers for the truth-table sweep controller.
// Rev 1.0
`default_nettype none

package tt_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  localparam int MAX_TT_W = 64;

  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

  // Operand is zero-extended to the widest legal table; returns 0 when no bit is set.
  function automatic int lowest_set_index(input logic [MAX_TT_W-1:0] v);
    int res;
    res = 0;
    for (int i = MAX_TT_W - 1; i >= 0; i--) begin
      if (v[i]) res = i;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tt_sweep_ctrl_tt_settle_timer.sv
// tt_settle_timer: 4-bit loadable down-counter providing the per-pattern settle delay.
// Rev 1.0
`default_nettype none

module tt_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 4'd0);

endmodule

`default_nettype wire

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: drives every input pattern into a combinational netlist, captures its
// truth table and compares it against an expected table latched at start. Rev 1.0
`default_nettype none

module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter  int N_IN   = 4,
  parameter  int SETTLE = 2,
  localparam int TT_W   = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [TT_W-1:0] expected_tt,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] result_tt,
  output logic [TT_W-1:0] mismatch,
  output logic            pass,
  output logic [N_IN-1:0] first_fail
);

  localparam logic [3:0]      SETTLE_V = 4'(SETTLE);
  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [TT_W-1:0] cap_q, cap_d;
  logic [TT_W-1:0] exp_q, exp_d;
  logic [TT_W-1:0] result_q, result_d;
  logic [TT_W-1:0] mism_q, mism_d;
  logic            pass_q, pass_d;
  logic [N_IN-1:0] ff_q, ff_d;

  logic                tmr_load;
  logic                tmr_dec;
  logic                tmr_zero;
  logic [TT_W-1:0]     cap_sample;
  logic [TT_W-1:0]     mism_sample;
  logic [MAX_TT_W-1:0] mism_ext;

  tt_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (SETTLE_V),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Capture as it will look once the current sample lands, so the final
  // compare can be registered on the same edge that enters REPORT.
  always_comb begin
    cap_sample        = cap_q;
    cap_sample[idx_q] = dut_out;
    mism_sample       = cap_sample ^ exp_q;
    mism_ext          = '0;
    mism_ext[TT_W-1:0] = mism_sample;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cap_d    = cap_q;
    exp_d    = exp_q;
    result_d = result_q;
    mism_d   = mism_q;
    pass_d   = pass_q;
    ff_d     = ff_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d  = ST_RUN;
          exp_d    = expected_tt;
          idx_d    = '0;
          cap_d    = '0;
          tmr_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
          cap_d = cap_sample;
          if (idx_q == IDX_LAST) begin
            state_d  = ST_REPORT;
            result_d = cap_sample;
            mism_d   = mism_sample;
            pass_d   = (mism_sample == '0);
            ff_d     = N_IN'(lowest_set_index(mism_ext));
          end else begin
            idx_d    = idx_q + 1'b1;
            tmr_load = 1'b1;
          end
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cap_q    <= '0;
      exp_q    <= '0;
      result_q <= '0;
      mism_q   <= '0;
      pass_q   <= 1'b0;
      ff_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cap_q    <= cap_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      mism_q   <= mism_d;
      pass_q   <= pass_d;
      ff_q     <= ff_d;
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_REPORT);
  assign dut_in     = busy ? idx_q : '0;
  assign result_tt  = result_q;
  assign mismatch   = mism_q;
  assign pass       = pass_q;
  assign first_fail = ff_q;

endmodule

`default_nettype wire
